// File: rtl/mmio_port_uart.sv
// Memory-mapped slave for the MEM stage: output/input ports plus a small
// TX FIFO that feeds an 8N1 UART serializer.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | line high, waiting for a byte in the FIFO
// S_START | start bit (line low) for one bit period
// S_DATA  | eight data bits, LSB first, one bit period each
// S_STOP  | stop bit (line high) for one bit period
module mmio_port_uart #(
  parameter logic [31:0] BASE_ADDR    = 32'h1001_1000,
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] ReadData,
  output logic        Hit,
  input  logic [7:0]  PortIn,
  output logic [31:0] PortOut,
  output logic        TxD
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [1:0] REG_PORT_OUT = 2'd0;
  localparam logic [1:0] REG_PORT_IN  = 2'd1;
  localparam logic [1:0] REG_TX_DATA  = 2'd2;
  localparam logic [1:0] REG_STATUS   = 2'd3;

  logic              hit;
  logic              wr_en;
  logic              rd_en;
  logic [1:0]        reg_sel;
  logic              unused_addr;

  logic [31:0]       port_out_q, port_out_d;
  logic [7:0]        sync1_q;
  logic [7:0]        sync2_q;

  logic [7:0]        fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push_req;
  logic              push;
  logic              pop;

  logic [1:0]        state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              baud_done;

  logic [31:0]       status;
  logic [31:0]       read_data;
  logic              txd;

  // Address decode ignores the strobes so the top level can mux on Hit alone.
  assign hit         = (Address[31:4] == BASE_ADDR[31:4]);
  assign reg_sel     = Address[3:2];
  assign wr_en       = MemWrite & hit;
  assign rd_en       = MemRead & hit;
  assign unused_addr = ^Address[1:0];

  assign fifo_full  = (count_q == CNT_FULL);
  assign fifo_empty = (count_q == '0);
  assign push_req   = wr_en && (reg_sel == REG_TX_DATA);
  assign push       = push_req && !fifo_full;
  assign pop        = (state_q == S_IDLE) && !fifo_empty;
  assign baud_done  = (baud_q == BAUD_LAST);

  always_comb begin
    port_out_d = port_out_q;
    if (wr_en && (reg_sel == REG_PORT_OUT)) begin
      port_out_d = WriteData;
    end
  end

  // Full is judged on the pre-edge count, so a same-cycle pop never rescues a write.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
    if (push_req && fifo_full) begin
      overflow_d = 1'b1;
    end else if (wr_en && (reg_sel == REG_STATUS) && WriteData[3]) begin
      overflow_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          shift_d = fifo_q[rd_ptr_q];
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (baud_done) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_STOP: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Decoded straight from state so reset forces the line high without a clock.
  always_comb begin
    case (state_q)
      S_START: txd = 1'b0;
      S_DATA:  txd = shift_q[0];
      default: txd = 1'b1;
    endcase
  end

  always_comb begin
    status               = '0;
    status[0]            = fifo_full;
    status[1]            = fifo_empty;
    status[2]            = (state_q != S_IDLE);
    status[3]            = overflow_q;
    status[4 +: CNT_W]   = count_q;
  end

  always_comb begin
    read_data = '0;
    if (rd_en) begin
      case (reg_sel)
        REG_PORT_OUT: read_data = port_out_q;
        REG_PORT_IN:  read_data = {24'b0, sync2_q};
        REG_TX_DATA:  read_data = '0;
        REG_STATUS:   read_data = status;
        default:      read_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      port_out_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
    end else begin
      port_out_q <= port_out_d;
      sync1_q    <= PortIn;
      sync2_q    <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= WriteData[7:0];
      end
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  assign ReadData = read_data;
  assign Hit      = hit;
  assign PortOut  = port_out_q;
  assign TxD      = txd;

endmodule
